// File: rtl/hyperbus_mem_responder.sv
// HyperBus native-interface memory responder.
// Serves word-addressed read/write bursts from an internal RAM. It models
// HyperRAM-style initial access latency and read-write recovery, so an
// initiator can be exercised without an external HyperBus device.
module hyperbus_mem_responder #(
   parameter int HBUS_ADDR_WIDTH = 32,
   parameter int HBUS_DATA_WIDTH = 16,
   parameter int MEM_ADDR_WIDTH  = 10,
   parameter int BURST_LEN       = 2,
   parameter int LATENCY         = 6,
   parameter int RWR             = 2
) (
   input  logic                       hbus_clk,
   input  logic                       hbus_rst,
   input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
   input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
   output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
   input  logic                       hbus_rrq,
   input  logic                       hbus_wrq,
   output logic                       hbus_ready,
   output logic                       hbus_valid,
   output logic                       hbus_busy
);

   localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

   // Counter reload values. Latency and recovery count down to zero, so they
   // are loaded one below their cycle count.
   localparam logic [7:0] LAT_INIT   = 8'(LATENCY - 1);
   localparam logic [7:0] BURST_INIT = 8'(BURST_LEN);
   localparam logic [7:0] RWR_INIT   = 8'(RWR - 1);

   localparam logic [MEM_ADDR_WIDTH-1:0] PTR_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_LAT     = 5'b00010,
      S_WRITE   = 5'b00100,
      S_READ    = 5'b01000,
      S_RECOVER = 5'b10000
   } state_t;

   state_t                      r_state,    w_state_nxt;
   logic [MEM_ADDR_WIDTH-1:0]   r_ptr,      w_ptr_nxt;
   logic [7:0]                  r_lat_cnt,  w_lat_nxt;
   logic [7:0]                  r_word_cnt, w_word_nxt;
   logic [7:0]                  r_rec_cnt,  w_rec_nxt;
   logic                        r_is_read,  w_is_read_nxt;
   logic                        r_busy,     w_busy_nxt;
   logic                        r_valid,    w_valid_nxt;
   logic                        r_ready,    w_ready_nxt;
   logic [HBUS_DATA_WIDTH-1:0]  r_dat,      w_dat_nxt;
   logic                        w_mem_we;
   logic [HBUS_DATA_WIDTH-1:0]  w_rd_word;

   // Only the low address bits index the RAM; the upper bits alias.
   logic                        w_adr_hi_unused;

   logic [HBUS_DATA_WIDTH-1:0]  r_mem [0:MEM_DEPTH-1];

   assign w_adr_hi_unused = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
   assign w_rd_word       = r_mem[r_ptr];

   assign hbus_dat_o = r_dat;
   assign hbus_valid = r_valid;
   assign hbus_ready = r_ready;
   assign hbus_busy  = r_busy;

   // Next-state and next-output logic for the transaction sequencer.
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_lat_nxt     = r_lat_cnt;
      w_word_nxt    = r_word_cnt;
      w_rec_nxt     = r_rec_cnt;
      w_is_read_nxt = r_is_read;
      w_busy_nxt    = r_busy;
      w_valid_nxt   = 1'b0;
      w_ready_nxt   = 1'b0;
      w_dat_nxt     = {HBUS_DATA_WIDTH{1'b0}};
      w_mem_we      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (hbus_rrq || hbus_wrq) begin
               // A simultaneous read and write request resolves to the read.
               w_ptr_nxt     = hbus_adr_i[MEM_ADDR_WIDTH-1:0];
               w_is_read_nxt = hbus_rrq;
               w_busy_nxt    = 1'b1;
               w_lat_nxt     = LAT_INIT;
               w_state_nxt   = S_LAT;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end

         S_LAT: begin
            if (r_lat_cnt == 8'd0) begin
               w_word_nxt  = BURST_INIT;
               w_state_nxt = r_is_read ? S_READ : S_WRITE;
            end else begin
               w_lat_nxt   = r_lat_cnt - 8'd1;
            end
         end

         S_READ: begin
            if (r_word_cnt != 8'd0) begin
               w_valid_nxt = 1'b1;
               w_dat_nxt   = w_rd_word;
               w_ptr_nxt   = r_ptr + PTR_ONE;
               w_word_nxt  = r_word_cnt - 8'd1;
            end else begin
               w_rec_nxt   = RWR_INIT;
               w_state_nxt = S_RECOVER;
            end
         end

         S_WRITE: begin
            // The first edge in WRITE only raises ready; each later edge
            // closes a ready cycle and commits the word on hbus_dat_i.
            if (r_ready) begin
               w_mem_we   = 1'b1;
               w_ptr_nxt  = r_ptr + PTR_ONE;
               w_word_nxt = r_word_cnt - 8'd1;
               if (r_word_cnt == 8'd1) begin
                  w_rec_nxt   = RWR_INIT;
                  w_state_nxt = S_RECOVER;
               end else begin
                  w_ready_nxt = 1'b1;
               end
            end else begin
               w_ready_nxt = 1'b1;
            end
         end

         S_RECOVER: begin
            if (r_rec_cnt == 8'd0) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_rec_nxt   = r_rec_cnt - 8'd1;
            end
         end

         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Sequencer state, counters and registered bus outputs.
   always_ff @(posedge hbus_clk or posedge hbus_rst) begin
      if (hbus_rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= {MEM_ADDR_WIDTH{1'b0}};
         r_lat_cnt  <= 8'd0;
         r_word_cnt <= 8'd0;
         r_rec_cnt  <= 8'd0;
         r_is_read  <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_ready    <= 1'b0;
         r_dat      <= {HBUS_DATA_WIDTH{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_lat_cnt  <= w_lat_nxt;
         r_word_cnt <= w_word_nxt;
         r_rec_cnt  <= w_rec_nxt;
         r_is_read  <= w_is_read_nxt;
         r_busy     <= w_busy_nxt;
         r_valid    <= w_valid_nxt;
         r_ready    <= w_ready_nxt;
         r_dat      <= w_dat_nxt;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge hbus_clk) begin
      if (w_mem_we) begin
         r_mem[r_ptr] <= hbus_dat_i;
      end
   end

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Directed bench for hyperbus_mem_responder (LATENCY=6, BURST_LEN=2, RWR=2).
// Expected per-cycle window relative to the request edge T0:
//   busy high for n=0..10, low at n=11; valid/ready high at n=7,8.
module tb_hyperbus_mem_responder;

   localparam int AW = 32;
   localparam int DW = 16;

   logic          hbus_clk = 1'b0;
   logic          hbus_rst;
   logic [AW-1:0] hbus_adr_i;
   logic [DW-1:0] hbus_dat_i;
   logic [DW-1:0] hbus_dat_o;
   logic          hbus_rrq;
   logic          hbus_wrq;
   logic          hbus_ready;
   logic          hbus_valid;
   logic          hbus_busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [31:0]   addr;
      logic [15:0]   w0;
      logic [15:0]   w1;
      logic [15:0]   e0;
      logic [15:0]   e1;
   } vec_t;

   vec_t vecs[11];

   always #5 hbus_clk = ~hbus_clk;

   hyperbus_mem_responder #(
      .HBUS_ADDR_WIDTH(32),
      .HBUS_DATA_WIDTH(16),
      .MEM_ADDR_WIDTH (10),
      .BURST_LEN      (2),
      .LATENCY        (6),
      .RWR            (2)
   ) dut (
      .hbus_clk   (hbus_clk),
      .hbus_rst   (hbus_rst),
      .hbus_adr_i (hbus_adr_i),
      .hbus_dat_i (hbus_dat_i),
      .hbus_dat_o (hbus_dat_o),
      .hbus_rrq   (hbus_rrq),
      .hbus_wrq   (hbus_wrq),
      .hbus_ready (hbus_ready),
      .hbus_valid (hbus_valid),
      .hbus_busy  (hbus_busy)
   );

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: {busy,valid,ready,dat} got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction, request dropped right after T0 (i.e. during LAT).
   task automatic run_txn(input vec_t v, input string name);
      @(negedge hbus_clk);
      hbus_adr_i = v.addr;
      hbus_rrq   = v.rd;
      hbus_wrq   = v.wr;
      hbus_dat_i = 16'hDEAD;
      @(posedge hbus_clk);
      #1;
      hbus_rrq   = 1'b0;
      hbus_wrq   = 1'b0;
      hbus_adr_i = 32'h0;
      for (int n = 0; n <= 11; n++) begin
         logic        eb, ev, er, win;
         logic [15:0] ed;
         if (n > 0) begin
            @(posedge hbus_clk);
            #1;
         end
         if (n == 7)      hbus_dat_i = v.w0;
         else if (n == 8) hbus_dat_i = v.w1;
         else             hbus_dat_i = 16'hDEAD;
         win = (n == 7) || (n == 8);
         eb  = (n <= 10);
         ev  = v.rd && win;
         er  = !v.rd && v.wr && win;
         ed  = ev ? ((n == 7) ? v.e0 : v.e1) : 16'h0000;
         check($sformatf("%s n=%0d", name, n),
               {hbus_busy, hbus_valid, hbus_ready, hbus_dat_o}, {eb, ev, er, ed});
      end
   endtask

   initial begin
      int vcount;
      hbus_rst   = 1'b0;
      hbus_adr_i = 32'h0;
      hbus_dat_i = 16'h0;
      hbus_rrq   = 1'b0;
      hbus_wrq   = 1'b0;
      #1 hbus_rst = 1'b1;

      //               rd    wr    addr          w0        w1        e0        e1
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 16'h1234, 16'hABCD, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 16'h0000, 16'h0000, 16'h1234, 16'hABCD};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_03FF, 16'hBEEF, 16'h5555, 16'h0000, 16'h0000};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_07FF, 16'h0000, 16'h0000, 16'hBEEF, 16'h5555};
      vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_FE00, 16'h0F0F, 16'hF0F0, 16'h0000, 16'h0000};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0200, 16'h0000, 16'h0000, 16'h0F0F, 16'hF0F0};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 16'h9999, 16'h8888, 16'h1234, 16'hABCD};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 16'h0000, 16'h0000, 16'h1234, 16'hABCD};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_0020, 16'h2020, 16'h2121, 16'h0000, 16'h0000};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0040, 16'h4040, 16'h4141, 16'h0000, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_0030, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000};

      // Reset state
      repeat (2) @(posedge hbus_clk);
      #1;
      check("reset_state", {hbus_busy, hbus_valid, hbus_ready, hbus_dat_o}, 19'h0);
      @(negedge hbus_clk);
      hbus_rst = 1'b0;

      // Table-driven transactions
      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset during the second write word: word 1 stays, word 2 is lost
      @(negedge hbus_clk);
      hbus_adr_i = 32'h30;
      hbus_wrq   = 1'b1;
      @(posedge hbus_clk);
      #1;
      hbus_wrq = 1'b0;
      repeat (7) begin
         @(posedge hbus_clk);
         #1;
      end
      hbus_dat_i = 16'h1111;
      check("rst_seq n=7", {hbus_busy, hbus_valid, hbus_ready, hbus_dat_o}, {3'b101, 16'h0000});
      @(posedge hbus_clk);
      #1;
      hbus_dat_i = 16'h2222;
      check("rst_seq n=8", {hbus_busy, hbus_valid, hbus_ready, hbus_dat_o}, {3'b101, 16'h0000});
      #2 hbus_rst = 1'b1;
      #1;
      check("rst_seq async", {hbus_busy, hbus_valid, hbus_ready, hbus_dat_o}, 19'h0);
      repeat (2) @(negedge hbus_clk);
      hbus_rst = 1'b0;
      run_txn('{1'b1, 1'b0, 32'h30, 16'h0, 16'h0, 16'h1111, 16'hBBBB}, "after_rst");

      // rrq held across two bursts; second uses address present at first IDLE edge
      @(negedge hbus_clk);
      hbus_adr_i = 32'h20;
      hbus_rrq   = 1'b1;
      @(posedge hbus_clk);
      #1;
      hbus_adr_i = 32'h40;
      vcount = 0;
      for (int n = 0; n <= 23; n++) begin
         logic        eb, ev;
         logic [15:0] ed;
         if (n > 0) begin
            @(posedge hbus_clk);
            #1;
         end
         if (n == 12) hbus_rrq = 1'b0;
         eb = (n <= 10) || (n >= 12 && n <= 22);
         ev = (n == 7) || (n == 8) || (n == 19) || (n == 20);
         case (n)
            7:       ed = 16'h2020;
            8:       ed = 16'h2121;
            19:      ed = 16'h4040;
            20:      ed = 16'h4141;
            default: ed = 16'h0000;
         endcase
         if (hbus_valid) vcount++;
         check($sformatf("held_rrq n=%0d", n),
               {hbus_busy, hbus_valid, hbus_ready, hbus_dat_o}, {eb, ev, 1'b0, ed});
      end
      checks++;
      if (vcount != 4) begin
         errors++;
         $display("FAIL held_rrq_valid_count: got %0d expected 4", vcount);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
